l2_mem_adapter: RTL and testbench

- Downstream stage of the coherence bus controller.
- Consumes the controller's single-word L2 request signals (l2REN/l2WEN/l2addr/l2store/l2_byte_en) and returns l2state/l2load/l2error.
- Converts these requests into a generic busy-handshaked memory-bus transaction.
- Takes over from the dummy L2 model in the bus testbench and in SoC integration. Adds latched requests, a timeout watchdog, and error reporting.

---
 rtl/l2_mem_adapter.sv | 138 +++++++++++++
 tb/tb_l2_mem_adapter.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/l2_mem_adapter.sv
// rtl/l2_mem_adapter.sv - L2 request to busy-handshaked memory bus adapter with watchdog
module l2_mem_adapter #(
    parameter int TIMEOUT_CYCLES = 64,
    parameter bit CHECK_ALIGN    = 1'b1
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        l2REN,
    input  logic        l2WEN,
    input  logic [31:0] l2addr,
    input  logic [31:0] l2store,
    input  logic [3:0]  l2_byte_en,
    output logic [1:0]  l2state,
    output logic [31:0] l2load,
    output logic        l2error,
    output logic        mem_ren,
    output logic        mem_wen,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_byte_en,
    input  logic [31:0] mem_rdata,
    input  logic        mem_busy,
    input  logic        mem_error
);

    // Encoding matches l2_state_t so the state register drives l2state directly.
    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERR    = 2'd3
    } state_t;

    localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t           state;
    state_t           next_state;
    logic             start;
    logic             complete;
    logic             timeout;
    logic             bad_req;
    logic [CNT_W-1:0] busy_cnt;

    // A single request with no byte lanes or a misaligned word address is unservable.
    assign bad_req = (l2_byte_en == 4'b0000) ||
                     (CHECK_ALIGN && (l2addr[1:0] != 2'b00));

    // State register.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= FREE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state decode plus the one-cycle control pulses used by the datapath.
    always_comb begin
        next_state = state;
        start      = 1'b0;
        complete   = 1'b0;
        timeout    = 1'b0;
        case (state)
            FREE: begin
                if (l2REN && l2WEN) begin
                    next_state = ERR;
                end else if (l2REN || l2WEN) begin
                    if (bad_req) begin
                        next_state = ERR;
                    end else begin
                        next_state = BUSY;
                        start      = 1'b1;
                    end
                end
            end
            BUSY: begin
                // The strobe is always high in BUSY, so completion is just !mem_busy.
                if (!mem_busy) begin
                    complete   = 1'b1;
                    next_state = mem_error ? ERR : ACCESS;
                end else if (busy_cnt == CNT_LAST) begin
                    timeout    = 1'b1;
                    next_state = ERR;
                end
            end
            ACCESS: begin
                next_state = FREE;
            end
            ERR: begin
                if (!l2REN && !l2WEN) begin
                    next_state = FREE;
                end
            end
            default: begin
                next_state = FREE;
            end
        endcase
    end

    // Latched request, memory strobes, watchdog counter and read-data capture.
    always_ff @(posedge CLK) begin
        if (RST) begin
            mem_ren     <= 1'b0;
            mem_wen     <= 1'b0;
            mem_addr    <= 32'h0;
            mem_wdata   <= 32'h0;
            mem_byte_en <= 4'h0;
            l2load      <= 32'h0;
            busy_cnt    <= '0;
        end else begin
            // Latching while FREE keeps the bus fields stable through BUSY regardless of l2addr/l2store.
            if ((state == FREE) && (l2REN ^ l2WEN)) begin
                mem_addr    <= l2addr;
                mem_wdata   <= l2store;
                mem_byte_en <= l2_byte_en;
            end
            if (start) begin
                mem_ren  <= l2REN;
                mem_wen  <= l2WEN;
                busy_cnt <= '0;
            end else if (complete || timeout) begin
                mem_ren <= 1'b0;
                mem_wen <= 1'b0;
            end
            if ((state == BUSY) && mem_busy) begin
                busy_cnt <= busy_cnt + CNT_W'(1);
            end
            if (complete && !mem_error && mem_ren) begin
                l2load <= mem_rdata;
            end
        end
    end

    assign l2state = state;
    assign l2error = (state == ERR);

endmodule

// File: tb/tb_l2_mem_adapter.sv
// tb/tb_l2_mem_adapter.sv - transaction-level self-checking bench for l2_mem_adapter
module tb_l2_mem_adapter;

    localparam int TO = 8;
    localparam logic [1:0] S_FREE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_ACC  = 2'd2;
    localparam logic [1:0] S_ERR  = 2'd3;

    logic        CLK = 1'b0;
    logic        RST;
    logic        l2REN, l2WEN;
    logic [31:0] l2addr, l2store;
    logic [3:0]  l2_byte_en;
    logic [1:0]  l2state;
    logic [31:0] l2load;
    logic        l2error;
    logic        mem_ren, mem_wen;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_byte_en;
    logic [31:0] mem_rdata;
    logic        mem_busy, mem_error;

    always #5 CLK = ~CLK;

    l2_mem_adapter #(.TIMEOUT_CYCLES(TO), .CHECK_ALIGN(1'b1)) dut (
        .CLK(CLK), .RST(RST),
        .l2REN(l2REN), .l2WEN(l2WEN), .l2addr(l2addr), .l2store(l2store),
        .l2_byte_en(l2_byte_en), .l2state(l2state), .l2load(l2load), .l2error(l2error),
        .mem_ren(mem_ren), .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_byte_en(mem_byte_en), .mem_rdata(mem_rdata), .mem_busy(mem_busy),
        .mem_error(mem_error)
    );

    int n_checks = 0;
    int n_fail = 0;
    logic check_en = 1'b0;
    int ren_cycles = 0;
    int wen_cycles = 0;

    // Expected outputs for the current cycle, set by the transaction tasks.
    logic [1:0]  exp_state = S_FREE;
    logic        exp_ren = 1'b0, exp_wen = 1'b0;
    logic [31:0] exp_addr = 32'h0, exp_wdata = 32'h0, exp_load = 32'h0;
    logic [3:0]  exp_be = 4'h0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, required 0x%08h at %0t", name, act, req, $time);
        end
    endtask

    always @(negedge CLK) begin
        if (check_en) begin
            chk("l2state", 32'(l2state), 32'(exp_state));
            chk("l2error", 32'(l2error), 32'(exp_state == S_ERR));
            chk("l2load", l2load, exp_load);
            chk("mem_ren", 32'(mem_ren), 32'(exp_ren));
            chk("mem_wen", 32'(mem_wen), 32'(exp_wen));
            if (exp_ren || exp_wen) begin
                chk("mem_addr", mem_addr, exp_addr);
                chk("mem_wdata", mem_wdata, exp_wdata);
                chk("mem_byte_en", 32'(mem_byte_en), 32'(exp_be));
            end
            if (mem_ren) ren_cycles++;
            if (mem_wen) wen_cycles++;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle(input int n);
        l2REN = 1'b0; l2WEN = 1'b0; mem_busy = 1'b0; mem_error = 1'b0;
        exp_state = S_FREE; exp_ren = 1'b0; exp_wen = 1'b0;
        repeat (n) step();
    endtask

    // Entered on the first ERR cycle: ERR persists while a request is high, then one cycle to FREE.
    task automatic err_tail(input int hold);
        exp_ren = 1'b0; exp_wen = 1'b0;
        if (l2REN || l2WEN) begin
            repeat (hold) begin
                exp_state = S_ERR;
                step();
            end
        end
        l2REN = 1'b0; l2WEN = 1'b0;
        exp_state = S_ERR;
        step();
        exp_state = S_FREE;
        step();
    endtask

    task automatic txn(input logic ren, input logic wen, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [3:0] be,
                       input logic [31:0] rdata, input int waits, input logic merr,
                       input logic withdraw, input int hold);
        logic legal;
        logic timed_out;
        int   strobe_cycles;
        legal = !(ren && wen) && (ren || wen) && (be != 4'h0) && (addr[1:0] == 2'b00);
        timed_out = (waits >= TO);
        strobe_cycles = timed_out ? TO : waits + 1;
        l2REN = ren; l2WEN = wen; l2addr = addr; l2store = wdata; l2_byte_en = be;
        mem_busy = 1'b0; mem_error = 1'b0;
        exp_state = S_FREE; exp_ren = 1'b0; exp_wen = 1'b0;
        step();
        if (!legal) begin
            err_tail(hold);
            return;
        end
        exp_addr = addr; exp_wdata = wdata; exp_be = be;
        for (int c = 1; c <= strobe_cycles; c++) begin
            logic last;
            last = !timed_out && (c == strobe_cycles);
            exp_state = S_BUSY; exp_ren = ren; exp_wen = wen;
            if (withdraw) begin
                l2REN = 1'b0; l2WEN = 1'b0;
            end
            l2addr = $urandom; l2store = $urandom; l2_byte_en = 4'($urandom);
            mem_busy  = !last;
            mem_rdata = last ? rdata : $urandom;
            mem_error = last ? merr : 1'($urandom);
            step();
        end
        mem_busy = 1'b0; mem_error = 1'b0;
        exp_ren = 1'b0; exp_wen = 1'b0;
        if (timed_out || merr) begin
            err_tail(hold);
        end else begin
            if (ren) exp_load = rdata;
            exp_state = S_ACC;
            l2REN = 1'b0; l2WEN = 1'b0;
            step();
            exp_state = S_FREE;
            step();
        end
    endtask

    initial begin
        RST = 1'b1; l2REN = 1'b0; l2WEN = 1'b0; l2addr = 32'h0; l2store = 32'h0;
        l2_byte_en = 4'h0; mem_rdata = 32'h0; mem_busy = 1'b0; mem_error = 1'b0;
        repeat (2) step();
        RST = 1'b0;
        chk("reset_l2state", 32'(l2state), 32'(S_FREE));
        chk("reset_mem_ren", 32'(mem_ren), 32'h0);
        chk("reset_l2load", l2load, 32'h0);
        check_en = 1'b1;
        idle(2);

        ren_cycles = 0;
        txn(1'b1, 1'b0, 32'h100, 32'h0, 4'hF, 32'hDEADBEEF, 0, 1'b0, 1'b0, 0);
        chk("read0_load", l2load, 32'hDEADBEEF);
        chk("read0_strobe_cycles", 32'(ren_cycles), 32'd1);

        wen_cycles = 0;
        txn(1'b0, 1'b1, 32'h204, 32'h12345678, 4'b0011, 32'h0, 5, 1'b0, 1'b0, 0);
        chk("write_strobe_cycles", 32'(wen_cycles), 32'd6);
        chk("write_keeps_load", l2load, 32'hDEADBEEF);

        ren_cycles = 0;
        txn(1'b1, 1'b0, 32'h300, 32'h0, 4'hF, 32'h0, 20, 1'b0, 1'b0, 3);
        chk("timeout_strobe_cycles", 32'(ren_cycles), 32'd8);

        ren_cycles = 0; wen_cycles = 0;
        txn(1'b1, 1'b1, 32'h400, 32'h0, 4'hF, 32'h0, 0, 1'b0, 1'b0, 2);
        txn(1'b1, 1'b0, 32'h102, 32'h0, 4'hF, 32'h0, 0, 1'b0, 1'b0, 1);
        txn(1'b0, 1'b1, 32'h500, 32'h55, 4'h0, 32'h0, 0, 1'b0, 1'b0, 0);
        chk("illegal_no_strobes", 32'(ren_cycles + wen_cycles), 32'd0);

        txn(1'b1, 1'b0, 32'h600, 32'h0, 4'hF, 32'hCAFEF00D, 2, 1'b1, 1'b0, 1);
        chk("mem_error_keeps_load", l2load, 32'hDEADBEEF);
        txn(1'b1, 1'b0, 32'h700, 32'h0, 4'hF, 32'hA5A5A5A5, 3, 1'b0, 1'b1, 0);
        chk("withdraw_load", l2load, 32'hA5A5A5A5);

        // Reset while a read is stalled with the strobe high.
        l2REN = 1'b1; l2WEN = 1'b0; l2addr = 32'h800; l2_byte_en = 4'hF; mem_busy = 1'b1;
        exp_state = S_FREE; exp_ren = 1'b0; exp_wen = 1'b0;
        step();
        exp_state = S_BUSY; exp_ren = 1'b1; exp_addr = 32'h800; exp_be = 4'hF; exp_wdata = l2store;
        step();
        RST = 1'b1; l2REN = 1'b0;
        step();
        RST = 1'b0; mem_busy = 1'b0;
        exp_state = S_FREE; exp_ren = 1'b0; exp_load = 32'h0;
        step();
        chk("reset_busy_load", l2load, 32'h0);
        chk("reset_busy_ren", 32'(mem_ren), 32'h0);

        for (int i = 0; i < 150; i++) begin
            logic        r, w;
            logic [31:0] a;
            logic [3:0]  b;
            int          op, wt;
            op = $urandom_range(0, 9);
            r = (op == 0) || (op < 5);
            w = (op == 0) || (op >= 5);
            a = {$urandom_range(0, 32'h3FFF), 2'b00};
            if ($urandom_range(0, 9) == 0) a[1:0] = 2'($urandom_range(1, 3));
            b = ($urandom_range(0, 9) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
            wt = ($urandom_range(0, 14) == 0) ? $urandom_range(TO, TO + 4) : $urandom_range(0, 4);
            txn(r, w, a, $urandom, b, $urandom, wt, ($urandom_range(0, 9) == 0),
                ($urandom_range(0, 4) == 0), $urandom_range(0, 2));
            idle($urandom_range(0, 2));
        end

        check_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
